// File: rtl/ex_mem_result_stage_pkg.sv
// rtl/ex_mem_result_stage_pkg.sv - shared constants and types for the EX/MEM result stage
//
// Purpose: opcode encodings, flag-update classes and FSM state encoding used by
//          ex_mem_result_stage and ex_mem_result_stage_flag_reg.
package ex_mem_result_stage_pkg;

    localparam int DW  = 16;
    localparam int RW  = 4;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD    = 4'h0;
    localparam logic [OPW-1:0] OP_SUB    = 4'h1;
    localparam logic [OPW-1:0] OP_XOR    = 4'h2;
    localparam logic [OPW-1:0] OP_RED    = 4'h3;
    localparam logic [OPW-1:0] OP_SLL    = 4'h4;
    localparam logic [OPW-1:0] OP_SRA    = 4'h5;
    localparam logic [OPW-1:0] OP_ROR    = 4'h6;
    localparam logic [OPW-1:0] OP_PADDSB = 4'h7;
    localparam logic [OPW-1:0] OP_LW     = 4'h8;
    localparam logic [OPW-1:0] OP_SW     = 4'h9;
    localparam logic [OPW-1:0] OP_HLT    = 4'hF;

    typedef enum logic [1:0] {
        FL_NONE = 2'd0,
        FL_Z    = 2'd1,
        FL_NZV  = 2'd2
    } flag_class_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // Which flags an accepted instruction is allowed to write.
    function automatic flag_class_e flag_class(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB:                 flag_class = FL_NZV;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_class = FL_Z;
            default:                        flag_class = FL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_result_stage_flag_reg.sv
// rtl/ex_mem_result_stage_flag_reg.sv - architectural N/Z/V flag register
//
// Purpose: holds N/Z/V; on en, writes the subset of flags selected by the
//          opcode's update class.
// Ports:   clk, rst (sync active-high), en (instruction accepted),
//          opcode, result (selected writeback value), ovfl (ADD/SUB saturation),
//          flag_n/flag_z/flag_v (registered flags).
module ex_mem_result_stage_flag_reg
    import ex_mem_result_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [OPW-1:0] opcode,
    input  logic [DW-1:0]  result,
    input  logic           ovfl,
    output logic           flag_n,
    output logic           flag_z,
    output logic           flag_v
);

    logic n_q, n_d;
    logic z_q, z_d;
    logic v_q, v_d;
    flag_class_e cls;

    always_comb begin
        cls = flag_class(opcode);
        n_d = n_q;
        z_d = z_q;
        v_d = v_q;
        if (en) begin
            case (cls)
                FL_NZV: begin
                    n_d = result[DW-1];
                    z_d = (result == '0);
                    v_d = ovfl;
                end
                FL_Z:    z_d = (result == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            n_q <= n_d;
            z_q <= z_d;
            v_q <= v_d;
        end
    end

    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_v = v_q;

endmodule

// File: rtl/ex_mem_result_stage.sv
// rtl/ex_mem_result_stage.sv - EX/MEM boundary: result select, flags, pipeline latch, HLT FSM
//
// Purpose: selects the writeback result by opcode, updates N/Z/V, and registers
//          the EX/MEM latch honouring stall, flush and HLT.
// Ports:   clk, rst (sync active-high), stall, flush;
//          ex_* execute-stage results and control;
//          mem_* registered MEM-stage outputs; flag_n/z/v; halted.
module ex_mem_result_stage
    import ex_mem_result_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic           ex_valid,
    input  logic [OPW-1:0] ex_opcode,
    input  logic [DW-1:0]  ex_alu_result,
    input  logic           ex_alu_ovfl,
    input  logic [DW-1:0]  ex_red_result,
    input  logic [DW-1:0]  ex_paddsb_result,
    input  logic [DW-1:0]  ex_store_data,
    input  logic [RW-1:0]  ex_rd,
    input  logic           ex_regwrite,
    input  logic           ex_memread,
    input  logic           ex_memwrite,
    output logic           mem_valid,
    output logic [DW-1:0]  mem_result,
    output logic [DW-1:0]  mem_store_data,
    output logic [RW-1:0]  mem_rd,
    output logic           mem_regwrite,
    output logic           mem_memread,
    output logic           mem_memwrite,
    output logic           mem_halt,
    output logic           flag_n,
    output logic           flag_z,
    output logic           flag_v,
    output logic           halted
);

    state_e         state_q, state_d;
    logic           valid_q, valid_d;
    logic [DW-1:0]  result_q, result_d;
    logic [DW-1:0]  store_q, store_d;
    logic [RW-1:0]  rd_q, rd_d;
    logic           regwrite_q, regwrite_d;
    logic           memread_q, memread_d;
    logic           memwrite_q, memwrite_d;
    logic           halt_q, halt_d;

    logic [DW-1:0]  sel_result;
    logic           accept;
    logic           is_hlt;
    logic           unused_red_hi;

    // The reduction adder never exceeds 120, so its upper bits carry no information.
    assign unused_red_hi = ^ex_red_result[DW-1:7];

    always_comb begin
        case (ex_opcode)
            OP_RED:    sel_result = {{(DW-7){1'b0}}, ex_red_result[6:0]};
            OP_PADDSB: sel_result = ex_paddsb_result;
            default:   sel_result = ex_alu_result;
        endcase
    end

    assign accept = ex_valid & ~stall & ~flush & (state_q == ST_RUN);
    assign is_hlt = (ex_opcode == OP_HLT);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        result_d   = result_q;
        store_d    = store_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        halt_d     = halt_q;

        if (accept) begin
            valid_d    = 1'b1;
            result_d   = sel_result;
            store_d    = ex_store_data;
            rd_d       = ex_rd;
            // HLT carries no side effects into MEM besides the halt marker.
            regwrite_d = ex_regwrite & ~is_hlt;
            memread_d  = ex_memread  & ~is_hlt;
            memwrite_d = ex_memwrite & ~is_hlt;
            halt_d     = is_hlt;
            if (is_hlt) begin
                state_d = ST_HALTED;
            end
        end else if (flush || !stall) begin
            // Bubble: flush, empty EX, or halted. Data fields keep their last value.
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            halt_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            valid_q    <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            halt_q     <= halt_d;
        end
    end

    ex_mem_result_stage_flag_reg u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .en     (accept),
        .opcode (ex_opcode),
        .result (sel_result),
        .ovfl   (ex_alu_ovfl),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_v (flag_v)
    );

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;
    assign mem_regwrite   = regwrite_q;
    assign mem_memread    = memread_q;
    assign mem_memwrite   = memwrite_q;
    assign mem_halt       = halt_q;
    assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ex_mem_result_stage.sv
// tb/tb_ex_mem_result_stage.sv - self-checking bench for ex_mem_result_stage
module tb_ex_mem_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_alu_result;
    logic        ex_alu_ovfl;
    logic [15:0] ex_red_result;
    logic [15:0] ex_paddsb_result;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite;
    logic        mem_valid;
    logic [15:0] mem_result, mem_store_data;
    logic [3:0]  mem_rd;
    logic        mem_regwrite, mem_memread, mem_memwrite, mem_halt;
    logic        flag_n, flag_z, flag_v, halted;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ex_mem_result_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_alu_result(ex_alu_result), .ex_alu_ovfl(ex_alu_ovfl),
        .ex_red_result(ex_red_result), .ex_paddsb_result(ex_paddsb_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_halt(mem_halt),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .halted(halted)
    );

    // Behavioural model of what MEM and the flags must hold after each edge.
    bit          m_valid, m_rw, m_mr, m_mw, m_halt, m_n, m_z, m_v, m_halted;
    logic [15:0] m_result, m_store;
    logic [3:0]  m_rd;
    bit          m_data_known;

    function automatic logic [15:0] pick_result(input logic [3:0] op, input logic [15:0] alu,
                                                input logic [15:0] red, input logic [15:0] padd);
        if (op == 4'd3) return red % 16'd128;
        if (op == 4'd7) return padd;
        return alu;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_halt, m_n, m_z, m_v, m_halted} = '0;
            m_result = 0; m_store = 0; m_rd = 0;
            m_data_known = 1'b1;
        end else begin
            m_data_known = 1'b0;
            if (stall && !flush) begin
                // everything frozen
            end else if (flush || !ex_valid || m_halted) begin
                {m_valid, m_rw, m_mr, m_mw, m_halt} = '0;
            end else begin
                logic [15:0] r;
                r = pick_result(ex_opcode, ex_alu_result, ex_red_result, ex_paddsb_result);
                m_valid = 1'b1;
                m_result = r;
                m_store = ex_store_data;
                m_rd = ex_rd;
                if (ex_opcode == 4'hF) begin
                    {m_rw, m_mr, m_mw} = '0;
                    m_halt = 1'b1;
                    m_halted = 1'b1;
                end else begin
                    m_rw = ex_regwrite; m_mr = ex_memread; m_mw = ex_memwrite;
                    m_halt = 1'b0;
                end
                if (ex_opcode == 4'd0 || ex_opcode == 4'd1) begin
                    m_n = r[15]; m_z = (r == 0); m_v = ex_alu_ovfl;
                end else if (ex_opcode inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
                    m_z = (r == 0);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_valid", 16'(mem_valid), 16'(m_valid));
            check("mem_regwrite", 16'(mem_regwrite), 16'(m_rw));
            check("mem_memread", 16'(mem_memread), 16'(m_mr));
            check("mem_memwrite", 16'(mem_memwrite), 16'(m_mw));
            check("mem_halt", 16'(mem_halt), 16'(m_halt));
            check("flag_n", 16'(flag_n), 16'(m_n));
            check("flag_z", 16'(flag_z), 16'(m_z));
            check("flag_v", 16'(flag_v), 16'(m_v));
            check("halted", 16'(halted), 16'(m_halted));
            if (m_valid || m_data_known) begin
                check("mem_result", mem_result, m_result);
                check("mem_store_data", mem_store_data, m_store);
                check("mem_rd", 16'(mem_rd), 16'(m_rd));
            end
        end
    end

    task automatic put(input bit v, input logic [3:0] op, input logic [15:0] alu, input bit ov,
                       input logic [15:0] red, input logic [15:0] padd, input logic [15:0] sd,
                       input logic [3:0] rd, input bit rw, input bit mr, input bit mw);
        ex_valid = v; ex_opcode = op; ex_alu_result = alu; ex_alu_ovfl = ov;
        ex_red_result = red; ex_paddsb_result = padd; ex_store_data = sd;
        ex_rd = rd; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        put(0, 4'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 4'h0, 0, 0, 0);
        tick(); tick();
        chk_en = 1'b1;
        check("rst_valid", 16'(mem_valid), 16'h0);
        check("rst_result", mem_result, 16'h0);
        check("rst_flags", {13'h0, flag_n, flag_z, flag_v}, 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        rst = 1'b0;

        // RED passes the low 7 bits, flags untouched.
        put(1, 4'h3, 16'hAAAA, 0, 16'h0078, 16'h0, 16'h0, 4'd3, 1, 0, 0);
        tick();
        check("t1_result", mem_result, 16'h0078);
        check("t1_rd", 16'(mem_rd), 16'd3);
        check("t1_flags", {13'h0, flag_n, flag_z, flag_v}, 16'h0);

        // ADD saturated, then XOR to zero.
        put(1, 4'h0, 16'h7FFF, 1, 16'h0, 16'h0, 16'h0, 4'd1, 1, 0, 0);
        tick();
        check("t2_add_flags", {13'h0, flag_n, flag_z, flag_v}, 16'b001);
        put(1, 4'h2, 16'h0000, 0, 16'h0, 16'h0, 16'h0, 4'd2, 1, 0, 0);
        tick();
        check("t2_xor_flags", {13'h0, flag_n, flag_z, flag_v}, 16'b011);

        // Stall with ADD res=0 in EX after a nonzero ADD.
        put(1, 4'h0, 16'h1234, 0, 16'h0, 16'h0, 16'h0, 4'd4, 1, 0, 0);
        tick();
        check("t3_pre_z", 16'(flag_z), 16'h0);
        put(1, 4'h0, 16'h0000, 0, 16'h0, 16'h0, 16'h0, 4'd5, 1, 0, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_result", mem_result, 16'h1234);
            check("t3_stall_z", 16'(flag_z), 16'h0);
        end
        stall = 1'b0;
        tick();
        check("t3_release_z", 16'(flag_z), 16'h1);
        check("t3_release_rd", 16'(mem_rd), 16'd5);

        // Flush and stall together with a SW in EX.
        put(1, 4'h9, 16'h0040, 0, 16'h0, 16'h0, 16'hBEEF, 4'd0, 0, 0, 1);
        flush = 1'b1; stall = 1'b1;
        tick();
        check("t4_valid", 16'(mem_valid), 16'h0);
        check("t4_memwrite", 16'(mem_memwrite), 16'h0);
        check("t4_flags", {13'h0, flag_n, flag_z, flag_v}, 16'b010);
        flush = 1'b0; stall = 1'b0;
        tick();
        check("sw_store", mem_store_data, 16'hBEEF);
        check("sw_memwrite", 16'(mem_memwrite), 16'h1);

        // Bubble, then PADDSB and LW.
        put(0, 4'h0, 16'h0005, 0, 16'h0, 16'h0, 16'h0, 4'd0, 1, 0, 0);
        tick();
        check("bubble_valid", 16'(mem_valid), 16'h0);
        put(1, 4'h7, 16'h1111, 0, 16'h0, 16'h7F80, 16'h0, 4'd6, 1, 0, 0);
        tick();
        check("paddsb_result", mem_result, 16'h7F80);
        put(1, 4'h8, 16'h0010, 0, 16'h0, 16'h0, 16'h0, 4'd7, 1, 1, 0);
        tick();
        check("lw_memread", 16'(mem_memread), 16'h1);

        // RED with high garbage bits clears to zero; flags unchanged.
        put(1, 4'h3, 16'h5555, 0, 16'hFF80, 16'h0, 16'h0, 4'd8, 1, 0, 0);
        tick();
        check("t6_result", mem_result, 16'h0000);
        check("t6_flags", {13'h0, flag_n, flag_z, flag_v}, 16'b010);

        // HLT, then a would-be flag-clearing ADD.
        put(1, 4'hF, 16'h0000, 0, 16'h0, 16'h0, 16'h0, 4'd9, 1, 1, 1);
        tick();
        check("t5_halt", 16'(mem_halt), 16'h1);
        check("t5_valid", 16'(mem_valid), 16'h1);
        check("t5_gated", {13'h0, mem_regwrite, mem_memread, mem_memwrite}, 16'h0);
        put(1, 4'h0, 16'h0005, 0, 16'h0, 16'h0, 16'h0, 4'd1, 1, 0, 0);
        tick();
        check("t5_halt_once", 16'(mem_halt), 16'h0);
        check("t5_bubble", 16'(mem_valid), 16'h0);
        check("t5_z_frozen", 16'(flag_z), 16'h1);
        check("t5_halted", 16'(halted), 16'h1);
        tick();
        check("t5_still_halted", 16'(halted), 16'h1);

        // Reset while halted and stalled.
        rst = 1'b1; stall = 1'b1;
        tick();
        check("t5_rst_halted", 16'(halted), 16'h0);
        check("t5_rst_outs", {mem_valid, mem_halt, flag_n, flag_z, flag_v, 11'h0}, 16'h0);
        rst = 1'b0; stall = 1'b0;
        put(1, 4'h1, 16'h8000, 0, 16'h0, 16'h0, 16'h0, 4'd2, 1, 0, 0);
        tick();
        check("post_rst_flags", {13'h0, flag_n, flag_z, flag_v}, 16'b100);
        check("post_rst_valid", 16'(mem_valid), 16'h1);
        put(0, 4'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0, 0);
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
